// File: rtl/midi_msg_decoder_pkg.sv
// Shared command codes, state encodings and byte-classification helpers
// for the MIDI byte-stream decoder.
package midi_msg_decoder_pkg;

  localparam int MIDI_CMD_SIZE = 4;

  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NONE     = 4'd0;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_OFF = 4'd1;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_ON  = 4'd2;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_POLY_AT  = 4'd3;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CC       = 4'd4;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PROG     = 4'd5;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CH_AT    = 4'd6;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PITCH    = 4'd7;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_SYS      = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D0 = 2'd1,
    ST_WAIT_D1 = 2'd2,
    ST_SKIP    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    BYTE_DATA   = 2'd0,
    BYTE_CHAN   = 2'd1,
    BYTE_SYSCOM = 2'd2,
    BYTE_RT     = 2'd3
  } byte_class_e;

  function automatic byte_class_e classify_byte(input logic [7:0] b);
    byte_class_e c;
    if (!b[7])                c = BYTE_DATA;
    else if (b[7:4] != 4'hF)  c = BYTE_CHAN;
    else if (b[3])            c = BYTE_RT;
    else                      c = BYTE_SYSCOM;
    return c;
  endfunction

  function automatic logic [MIDI_CMD_SIZE-1:0] status_cmd(input logic [3:0] hi);
    logic [MIDI_CMD_SIZE-1:0] c;
    case (hi)
      4'h8:    c = MIDI_CMD_NOTE_OFF;
      4'h9:    c = MIDI_CMD_NOTE_ON;
      4'hA:    c = MIDI_CMD_POLY_AT;
      4'hB:    c = MIDI_CMD_CC;
      4'hC:    c = MIDI_CMD_PROG;
      4'hD:    c = MIDI_CMD_CH_AT;
      4'hE:    c = MIDI_CMD_PITCH;
      default: c = MIDI_CMD_NONE;
    endcase
    return c;
  endfunction

  // Program change and channel aftertouch carry a single data byte.
  function automatic logic status_need_two(input logic [3:0] hi);
    return !((hi == 4'hC) || (hi == 4'hD));
  endfunction

endpackage

// File: rtl/midi_msg_decoder_if.sv
// Byte-stream input and parallel command bus of the MIDI decoder.
// rx_byte_rdy is a one-cycle strobe with no back-pressure: the decoder
// consumes every byte whose strobe is high; midi_rdy and err_drop are
// likewise one-cycle strobes and the sink must take them when they fire.
interface midi_msg_decoder_if;
  import midi_msg_decoder_pkg::*;

  logic                     rx_byte_rdy;
  logic [7:0]               rx_byte;
  logic                     midi_rdy;
  logic [MIDI_CMD_SIZE-1:0] midi_cmd;
  logic [3:0]               midi_ch_sysn;
  logic [6:0]               midi_data0;
  logic [6:0]               midi_data1;
  logic                     err_drop;
  state_e                   dbg_state;

  modport master (
    output rx_byte_rdy, rx_byte,
    input  midi_rdy, midi_cmd, midi_ch_sysn, midi_data0, midi_data1,
           err_drop, dbg_state
  );

  modport slave (
    input  rx_byte_rdy, rx_byte,
    output midi_rdy, midi_cmd, midi_ch_sysn, midi_data0, midi_data1,
           err_drop, dbg_state
  );

endinterface

// File: rtl/midi_msg_decoder.sv
// MIDI byte stream to parallel command decoder with running status,
// real-time passthrough and SysEx/system-common skipping.
module midi_msg_decoder
  import midi_msg_decoder_pkg::*;
#(
  parameter bit NOTE_ON_VEL0_AS_OFF = 1'b1
) (
  input logic              clk,
  input logic              reset,
  midi_msg_decoder_if.slave bus
);

  state_e                   state_q, state_d;
  logic [MIDI_CMD_SIZE-1:0] rs_cmd_q, rs_cmd_d;
  logic [3:0]               rs_ch_q, rs_ch_d;
  logic                     need_two_q, need_two_d;
  logic [6:0]               d0_q, d0_d;

  logic                     rdy_q, rdy_d;
  logic                     err_q, err_d;
  logic [MIDI_CMD_SIZE-1:0] cmd_q, cmd_d;
  logic [3:0]               ch_q, ch_d;
  logic [6:0]               data0_q, data0_d;
  logic [6:0]               data1_q, data1_d;

  logic [7:0]  rx_b;
  byte_class_e rx_class;

  assign rx_b     = bus.rx_byte;
  assign rx_class = classify_byte(rx_b);

  always_comb begin
    state_d    = state_q;
    rs_cmd_d   = rs_cmd_q;
    rs_ch_d    = rs_ch_q;
    need_two_d = need_two_q;
    d0_d       = d0_q;
    rdy_d      = 1'b0;
    err_d      = 1'b0;
    cmd_d      = cmd_q;
    ch_d       = ch_q;
    data0_d    = data0_q;
    data1_d    = data1_q;

    if (bus.rx_byte_rdy) begin
      unique case (rx_class)
        // Real-time bytes interleave anywhere and must not disturb parsing.
        BYTE_RT: begin
          rdy_d   = 1'b1;
          cmd_d   = MIDI_CMD_SYS;
          ch_d    = rx_b[3:0];
          data0_d = 7'd0;
          data1_d = 7'd0;
        end
        BYTE_SYSCOM: begin
          rs_cmd_d   = MIDI_CMD_NONE;
          rs_ch_d    = 4'd0;
          need_two_d = 1'b0;
          state_d    = (rx_b == 8'hF7) ? ST_IDLE : ST_SKIP;
        end
        BYTE_CHAN: begin
          rs_cmd_d   = status_cmd(rx_b[7:4]);
          rs_ch_d    = rx_b[3:0];
          need_two_d = status_need_two(rx_b[7:4]);
          state_d    = ST_WAIT_D0;
        end
        BYTE_DATA: begin
          unique case (state_q)
            ST_IDLE: err_d = 1'b1;
            ST_WAIT_D0: begin
              if (need_two_q) begin
                d0_d    = rx_b[6:0];
                state_d = ST_WAIT_D1;
              end else begin
                rdy_d   = 1'b1;
                cmd_d   = rs_cmd_q;
                ch_d    = rs_ch_q;
                data0_d = rx_b[6:0];
                data1_d = 7'd0;
              end
            end
            ST_WAIT_D1: begin
              rdy_d   = 1'b1;
              cmd_d   = rs_cmd_q;
              ch_d    = rs_ch_q;
              data0_d = d0_q;
              data1_d = rx_b[6:0];
              state_d = ST_WAIT_D0;
              if (NOTE_ON_VEL0_AS_OFF && (rs_cmd_q == MIDI_CMD_NOTE_ON) &&
                  (rx_b[6:0] == 7'd0)) begin
                cmd_d = MIDI_CMD_NOTE_OFF;
              end
            end
            ST_SKIP: ;
            default: state_d = ST_IDLE;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rs_cmd_q   <= MIDI_CMD_NONE;
      rs_ch_q    <= 4'd0;
      need_two_q <= 1'b0;
      d0_q       <= 7'd0;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
      cmd_q      <= MIDI_CMD_NONE;
      ch_q       <= 4'd0;
      data0_q    <= 7'd0;
      data1_q    <= 7'd0;
    end else begin
      state_q    <= state_d;
      rs_cmd_q   <= rs_cmd_d;
      rs_ch_q    <= rs_ch_d;
      need_two_q <= need_two_d;
      d0_q       <= d0_d;
      rdy_q      <= rdy_d;
      err_q      <= err_d;
      cmd_q      <= cmd_d;
      ch_q       <= ch_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
    end
  end

  assign bus.midi_rdy     = rdy_q;
  assign bus.err_drop     = err_q;
  assign bus.midi_cmd     = cmd_q;
  assign bus.midi_ch_sysn = ch_q;
  assign bus.midi_data0   = data0_q;
  assign bus.midi_data1   = data1_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_midi_msg_decoder.sv
// Bench for midi_msg_decoder: two instances (velocity-0 remap on and off)
// fed the same byte stream and checked against a message-level model.
module tb_midi_msg_decoder;
  import midi_msg_decoder_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  midi_msg_decoder_if bus_a ();
  midi_msg_decoder_if bus_b ();

  midi_msg_decoder #(.NOTE_ON_VEL0_AS_OFF(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  midi_msg_decoder #(.NOTE_ON_VEL0_AS_OFF(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // Observation vector per instance: {rdy, err, cmd[3:0], ch[3:0], d0[6:0], d1[6:0]}
  int n_cmp = 0;
  int n_fail = 0;
  logic [47:0] exp_q[$];
  logic [47:0] obs_v;
  logic [47:0] e;

  // Message-level reference model
  bit         m_rs_valid;
  logic [7:0] m_rs_status;
  bit         m_skip;
  logic [6:0] m_data[$];
  logic [21:0] m_last_a, m_last_b;

  task automatic model_reset();
    m_rs_valid = 0; m_rs_status = 8'h00; m_skip = 0;
    m_data.delete();
    m_last_a = '0; m_last_b = '0;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [1:0] flags;
    int need;
    logic [3:0] cmd, cmd_a;
    logic [6:0] d0, d1;
    flags = 2'b00;
    if (b >= 8'hF8) begin
      m_last_a = {MIDI_CMD_SYS, b[3:0], 14'd0};
      m_last_b = m_last_a;
      flags = 2'b10;
    end else if (b >= 8'hF0) begin
      m_rs_valid = 0;
      m_skip = (b != 8'hF7);
      m_data.delete();
    end else if (b >= 8'h80) begin
      m_rs_valid = 1;
      m_rs_status = b;
      m_skip = 0;
      m_data.delete();
    end else if (m_skip) begin
      flags = 2'b00;
    end else if (!m_rs_valid) begin
      flags = 2'b01;
    end else begin
      m_data.push_back(b[6:0]);
      need = (m_rs_status[7:4] == 4'hC || m_rs_status[7:4] == 4'hD) ? 1 : 2;
      if (m_data.size() == need) begin
        cmd = m_rs_status[7:4] - 4'd7;
        d0 = m_data[0];
        d1 = (need == 2) ? m_data[1] : 7'd0;
        cmd_a = (cmd == MIDI_CMD_NOTE_ON && d1 == 7'd0) ? MIDI_CMD_NOTE_OFF : cmd;
        m_last_a = {cmd_a, m_rs_status[3:0], d0, d1};
        m_last_b = {cmd, m_rs_status[3:0], d0, d1};
        flags = 2'b10;
        m_data.delete();
      end
    end
    exp_q.push_back({flags, m_last_a, flags, m_last_b});
  endtask

  task automatic sample();
    obs_v = {bus_a.midi_rdy, bus_a.err_drop, bus_a.midi_cmd, bus_a.midi_ch_sysn,
             bus_a.midi_data0, bus_a.midi_data1,
             bus_b.midi_rdy, bus_b.err_drop, bus_b.midi_cmd, bus_b.midi_ch_sysn,
             bus_b.midi_data0, bus_b.midi_data1};
  endtask

  // Drives one strobe (inputs change at posedge+1) and samples at the next posedge+1.
  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    bus_a.rx_byte_rdy = 1'b1; bus_a.rx_byte = b;
    bus_b.rx_byte_rdy = 1'b1; bus_b.rx_byte = b;
    @(posedge clk); #1;
    sample();
    bus_a.rx_byte_rdy = 1'b0;
    bus_b.rx_byte_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
    sample();
  endtask

  task automatic apply_reset();
    bus_a.rx_byte_rdy = 1'b0; bus_a.rx_byte = 8'h00;
    bus_b.rx_byte_rdy = 1'b0; bus_b.rx_byte = 8'h00;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [7:0] v;
    r = $urandom_range(0, 99);
    v = 8'($urandom_range(0, 255));
    if (r < 55)      return {1'b0, v[6:0]};
    else if (r < 80) return 8'($urandom_range(8'h80, 8'hEF));
    else if (r < 90) return {5'b11111, v[2:0]};
    else             return {5'b11110, v[2:0]};
  endfunction

  task automatic test_reset();
    #2 reset = 1'b0;
    bus_a.rx_byte_rdy = 1'b0; bus_a.rx_byte = 8'h00;
    bus_b.rx_byte_rdy = 1'b0; bus_b.rx_byte = 8'h00;
    #1 sample();
    n_cmp++;
    if (obs_v !== 48'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=%h", obs_v, 48'd0);
    end
    apply_reset();
  endtask

  task automatic test_note_on();
    logic [7:0] seq[3] = '{8'h90, 8'h32, 8'h30};
    foreach (seq[i]) begin
      send_byte(seq[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== e) begin
        n_fail++;
        $display("FAIL note_on byte=%h got=%h exp=%h", seq[i], obs_v, e);
      end
    end
    n_cmp++;
    if (obs_v[47:24] !== {2'b10, MIDI_CMD_NOTE_ON, 4'd0, 7'd50, 7'd48}) begin
      n_fail++;
      $display("FAIL note_on_fields got=%h exp=%h", obs_v[47:24],
               {2'b10, MIDI_CMD_NOTE_ON, 4'd0, 7'd50, 7'd48});
    end
  endtask

  task automatic test_running_status();
    logic [7:0] seq[5] = '{8'h91, 8'h3C, 8'h40, 8'h3E, 8'h40};
    foreach (seq[i]) begin
      send_byte(seq[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== e) begin
        n_fail++;
        $display("FAIL running_status byte=%h got=%h exp=%h", seq[i], obs_v, e);
      end
    end
    idle(1);
    n_cmp++;
    if (obs_v !== {2'b00, m_last_a, 2'b00, m_last_b}) begin
      n_fail++;
      $display("FAIL strobe_hold got=%h exp=%h", obs_v, {2'b00, m_last_a, 2'b00, m_last_b});
    end
  endtask

  task automatic test_vel0();
    logic [7:0] seq[3] = '{8'h92, 8'h3C, 8'h00};
    foreach (seq[i]) begin
      send_byte(seq[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== e) begin
        n_fail++;
        $display("FAIL vel0 byte=%h got=%h exp=%h", seq[i], obs_v, e);
      end
    end
    n_cmp++;
    if ({obs_v[45:42], obs_v[21:18]} !== {MIDI_CMD_NOTE_OFF, MIDI_CMD_NOTE_ON}) begin
      n_fail++;
      $display("FAIL vel0_cmds got=%h exp=%h", {obs_v[45:42], obs_v[21:18]},
               {MIDI_CMD_NOTE_OFF, MIDI_CMD_NOTE_ON});
    end
  endtask

  task automatic test_realtime();
    logic [7:0] seq[4] = '{8'hB0, 8'h07, 8'hF8, 8'h64};
    foreach (seq[i]) begin
      send_byte(seq[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== e) begin
        n_fail++;
        $display("FAIL realtime byte=%h got=%h exp=%h", seq[i], obs_v, e);
      end
    end
  endtask

  task automatic test_prog();
    logic [7:0] seq[3] = '{8'hC5, 8'h0A, 8'h0B};
    foreach (seq[i]) begin
      send_byte(seq[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== e) begin
        n_fail++;
        $display("FAIL prog byte=%h got=%h exp=%h", seq[i], obs_v, e);
      end
    end
  endtask

  task automatic test_async_reset();
    send_byte(8'h90); e = exp_q.pop_front();
    send_byte(8'h32); e = exp_q.pop_front();
    #2 reset = 1'b0;
    #1 sample();
    model_reset();
    n_cmp++;
    if (obs_v !== 48'd0) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=%h", obs_v, 48'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    send_byte(8'h30);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs_v !== e || obs_v[46] !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_drop got=%h exp=%h", obs_v, e);
    end
  endtask

  task automatic test_err_sysex();
    logic [7:0] seq[6] = '{8'h40, 8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h10};
    apply_reset();
    foreach (seq[i]) begin
      send_byte(seq[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== e) begin
        n_fail++;
        $display("FAIL sysex_err byte=%h got=%h exp=%h", seq[i], obs_v, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    for (int i = 0; i < 100; i++) begin
      b = rand_byte();
      send_byte(b);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== e) begin
        n_fail++;
        $display("FAIL back_to_back idx=%0d byte=%h got=%h exp=%h", i, b, obs_v, e);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 300; i++) begin
      b = rand_byte();
      send_byte(b);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_v !== e) begin
        n_fail++;
        $display("FAIL random idx=%0d byte=%h got=%h exp=%h", i, b, obs_v, e);
      end
      if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(1, 3));
        n_cmp++;
        if (obs_v !== {2'b00, m_last_a, 2'b00, m_last_b}) begin
          n_fail++;
          $display("FAIL random_idle idx=%0d got=%h exp=%h", i, obs_v,
                   {2'b00, m_last_a, 2'b00, m_last_b});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_vel0();
    test_realtime();
    test_prog();
    test_async_reset();
    test_err_sysex();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
